// File: rtl/ulpi_phy_emu_if.sv
// ULPI link-side bus between a link and the emulated PHY.
// Signal names follow the PHY's point of view (_i = driven by link, _o = driven by PHY).
interface ulpi_phy_emu_if;
    logic [7:0] ulpi_data_i;  // driven by the link while dir=0
    logic [7:0] ulpi_data_o;  // driven by the PHY while dir=1
    logic       ulpi_dir_o;
    logic       ulpi_nxt_o;
    logic       ulpi_stp_i;

    modport slave (
        input  ulpi_data_i,
        input  ulpi_stp_i,
        output ulpi_data_o,
        output ulpi_dir_o,
        output ulpi_nxt_o
    );

    modport master (
        output ulpi_data_i,
        output ulpi_stp_i,
        input  ulpi_data_o,
        input  ulpi_dir_o,
        input  ulpi_nxt_o
    );
endinterface

// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI responder: services link TX CMDs (register write/read, transmit),
// injects received packets and emits RX CMDs on LineState changes.
module ulpi_phy_emu #(
    parameter logic [15:0] VENDOR_ID     = 16'h0424,
    parameter logic [15:0] PRODUCT_ID    = 16'h0009,
    parameter logic [7:0]  FUNC_CTRL_RST = 8'h41,
    parameter logic [7:0]  IF_CTRL_RST   = 8'h00,
    parameter logic [7:0]  OTG_CTRL_RST  = 8'h06
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ulpi_phy_emu_if.slave        ulpi,
    input  logic [1:0]           linestate_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_last_i,
    output logic                 rx_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_last_o
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CMD_ACK = 4'd1;
    localparam logic [3:0] S_W_DATA  = 4'd2;
    localparam logic [3:0] S_W_STP   = 4'd3;
    localparam logic [3:0] S_R_TA1   = 4'd4;
    localparam logic [3:0] S_R_DATA  = 4'd5;
    localparam logic [3:0] S_R_TA2   = 4'd6;
    localparam logic [3:0] S_TX_DATA = 4'd7;
    localparam logic [3:0] S_RX_TA1  = 4'd8;
    localparam logic [3:0] S_RX_DATA = 4'd9;
    localparam logic [3:0] S_RX_END  = 4'd10;
    localparam logic [3:0] S_RX_TA2  = 4'd11;
    localparam logic [3:0] S_LS_TA1  = 4'd12;
    localparam logic [3:0] S_LS_CMD  = 4'd13;
    localparam logic [3:0] S_LS_TA2  = 4'd14;

    logic [3:0] r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_wdata;
    logic       r_dir;
    logic       r_nxt;
    logic [7:0] r_data_o;
    logic [7:0] r_func_ctrl;
    logic [7:0] r_if_ctrl;
    logic [7:0] r_otg_ctrl;
    logic [1:0] r_ls;
    logic [7:0] r_tx_hold;
    logic       r_tx_valid;
    logic [7:0] r_tx_data;
    logic       r_tx_last;
    logic       r_rx_last;

    logic [7:0] w_rd_data;
    logic [7:0] w_rxcmd_active;
    logic [7:0] w_rxcmd_idle;
    logic       w_stp;

    // RX CMD: {2'b00, rxevent, 2'b11, linestate}
    assign w_rxcmd_active = {2'b00, 2'b01, 2'b11, linestate_i};
    assign w_rxcmd_idle   = {2'b00, 2'b00, 2'b11, linestate_i};
    // stp only means something while the link owns the bus
    assign w_stp          = ulpi.ulpi_stp_i & ~r_dir;

    // A byte is consumed whenever the packet path can take it; after the last byte it stops.
    assign rx_ready_o = rx_valid_i &
                        ((r_state == S_RX_TA1) || ((r_state == S_RX_DATA) && !r_rx_last));

    assign ulpi.ulpi_data_o = r_data_o;
    assign ulpi.ulpi_dir_o  = r_dir;
    assign ulpi.ulpi_nxt_o  = r_nxt;
    assign tx_valid_o       = r_tx_valid;
    assign tx_data_o        = r_tx_data;
    assign tx_last_o        = r_tx_last;

    // Register read mux; base/set/clear aliases all read back the register value
    always_comb begin
        w_rd_data = 8'h00;
        case (r_cmd[5:0])
            6'h00:               w_rd_data = VENDOR_ID[7:0];
            6'h01:               w_rd_data = VENDOR_ID[15:8];
            6'h02:               w_rd_data = PRODUCT_ID[7:0];
            6'h03:               w_rd_data = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06: w_rd_data = r_func_ctrl;
            6'h07, 6'h08, 6'h09: w_rd_data = r_if_ctrl;
            6'h0A, 6'h0B, 6'h0C: w_rd_data = r_otg_ctrl;
            default:             w_rd_data = 8'h00;
        endcase
    end

    // Register file: commit on the W_STP edge; Function Control bit 5 (reset) self-clears
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_func_ctrl <= FUNC_CTRL_RST;
            r_if_ctrl   <= IF_CTRL_RST;
            r_otg_ctrl  <= OTG_CTRL_RST;
        end else if (r_state == S_W_STP) begin
            case (r_cmd[5:0])
                6'h04:   r_func_ctrl <= r_wdata;
                6'h05:   r_func_ctrl <= r_func_ctrl | r_wdata;
                6'h06:   r_func_ctrl <= r_func_ctrl & ~r_wdata;
                6'h07:   r_if_ctrl   <= r_wdata;
                6'h08:   r_if_ctrl   <= r_if_ctrl | r_wdata;
                6'h09:   r_if_ctrl   <= r_if_ctrl & ~r_wdata;
                6'h0A:   r_otg_ctrl  <= r_wdata;
                6'h0B:   r_otg_ctrl  <= r_otg_ctrl | r_wdata;
                6'h0C:   r_otg_ctrl  <= r_otg_ctrl & ~r_wdata;
                default: ;
            endcase
        end else begin
            r_func_ctrl[5] <= 1'b0;
        end
    end

    // Bus FSM: state plus every registered ULPI / tx output
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cmd      <= 8'h00;
            r_wdata    <= 8'h00;
            r_dir      <= 1'b0;
            r_nxt      <= 1'b0;
            r_data_o   <= 8'h00;
            r_ls       <= 2'b00;
            r_tx_hold  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_last  <= 1'b0;
            r_rx_last  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dir     <= 1'b0;
                    r_nxt     <= 1'b0;
                    r_data_o  <= 8'h00;
                    // Seed the tx hold stage with the PID byte in case this is a Transmit
                    r_tx_hold <= {~ulpi.ulpi_data_i[3:0], ulpi.ulpi_data_i[3:0]};
                    if (rx_valid_i) begin
                        r_state   <= S_RX_TA1;
                        r_dir     <= 1'b1;
                        r_nxt     <= 1'b1;
                        r_rx_last <= 1'b0;
                    end else if (linestate_i != r_ls) begin
                        r_state <= S_LS_TA1;
                        r_dir   <= 1'b1;
                    end else if (ulpi.ulpi_data_i[7:6] != 2'b00) begin
                        r_state <= S_CMD_ACK;
                        r_cmd   <= ulpi.ulpi_data_i;
                        r_nxt   <= 1'b1;
                    end
                end
                S_CMD_ACK: begin
                    case (r_cmd[7:6])
                        2'b10: begin
                            r_state <= S_W_DATA;
                            r_nxt   <= 1'b1;
                        end
                        2'b11: begin
                            r_state  <= S_R_TA1;
                            r_dir    <= 1'b1;
                            r_nxt    <= 1'b0;
                            r_data_o <= 8'h00;
                        end
                        default: begin
                            r_state <= S_TX_DATA;
                            r_nxt   <= 1'b1;
                        end
                    endcase
                end
                S_W_DATA: begin
                    r_wdata <= ulpi.ulpi_data_i;
                    r_nxt   <= 1'b0;
                    r_state <= S_W_STP;
                end
                S_W_STP: begin
                    r_state <= S_IDLE;
                end
                S_R_TA1: begin
                    r_data_o <= w_rd_data;
                    r_state  <= S_R_DATA;
                end
                S_R_DATA: begin
                    r_dir    <= 1'b0;
                    r_data_o <= 8'h00;
                    r_state  <= S_R_TA2;
                end
                S_R_TA2: begin
                    r_state <= S_IDLE;
                end
                S_TX_DATA: begin
                    // Held byte leaves on every edge; stp marks it last and drops bus data
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= r_tx_hold;
                    if (w_stp) begin
                        r_tx_last <= 1'b1;
                        r_nxt     <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tx_hold <= ulpi.ulpi_data_i;
                        r_nxt     <= 1'b1;
                    end
                end
                S_RX_TA1, S_RX_DATA: begin
                    if ((r_state == S_RX_DATA) && r_rx_last) begin
                        r_data_o <= w_rxcmd_idle;
                        r_nxt    <= 1'b0;
                        r_ls     <= linestate_i;
                        r_state  <= S_RX_END;
                    end else if (rx_valid_i) begin
                        r_data_o  <= rx_data_i;
                        r_nxt     <= 1'b1;
                        r_rx_last <= rx_last_i;
                        r_state   <= S_RX_DATA;
                    end else begin
                        // Source stalled: fill the gap with an RX CMD, rxevent = active
                        r_data_o <= w_rxcmd_active;
                        r_nxt    <= 1'b0;
                        r_ls     <= linestate_i;
                        r_state  <= S_RX_DATA;
                    end
                end
                S_RX_END: begin
                    r_dir    <= 1'b0;
                    r_nxt    <= 1'b0;
                    r_data_o <= 8'h00;
                    r_state  <= S_RX_TA2;
                end
                S_RX_TA2: begin
                    r_state <= S_IDLE;
                end
                S_LS_TA1: begin
                    r_data_o <= w_rxcmd_idle;
                    r_ls     <= linestate_i;
                    r_state  <= S_LS_CMD;
                end
                S_LS_CMD: begin
                    r_dir    <= 1'b0;
                    r_data_o <= 8'h00;
                    r_state  <= S_LS_TA2;
                end
                S_LS_TA2: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_dir    <= 1'b0;
                    r_nxt    <= 1'b0;
                    r_data_o <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Directed bench for ulpi_phy_emu: plays the link side and checks cycle timing.
module tb_ulpi_phy_emu;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] linestate_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_last_i;
    logic       rx_ready_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_last_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] tx_q[$];
    logic       tx_last_q[$];

    ulpi_phy_emu_if u_if ();

    ulpi_phy_emu u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ulpi        (u_if),
        .linestate_i (linestate_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_last_i   (rx_last_i),
        .rx_ready_o  (rx_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_last_o   (tx_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Collect the transmitted stream away from the active edge
    always @(negedge clk_i) begin
        if (tx_valid_o) begin
            tx_q.push_back(tx_data_o);
            tx_last_q.push_back(tx_last_o);
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Link-side RegRead; trace = {nxt@N+1, dir@N+2, dir@N+3, dir@N+4}
    task automatic reg_read(input logic [5:0] a, output logic [7:0] d, output logic [3:0] tr);
        u_if.ulpi_data_i = {2'b11, a};
        tick();
        tr[3] = u_if.ulpi_nxt_o;
        tick();
        u_if.ulpi_data_i = 8'h00;
        tr[2] = u_if.ulpi_dir_o;
        tick();
        tr[1] = u_if.ulpi_dir_o;
        d     = u_if.ulpi_data_o;
        tick();
        tr[0] = u_if.ulpi_dir_o;
        tick();
    endtask

    // Link-side RegWrite; trace = {nxt@N+1, nxt@N+2, nxt@N+3}; returns at N+4
    task automatic reg_write(input logic [5:0] a, input logic [7:0] v, output logic [2:0] tr);
        u_if.ulpi_data_i = {2'b10, a};
        tick();
        tr[2] = u_if.ulpi_nxt_o;
        u_if.ulpi_data_i = v;
        tick();
        tr[1] = u_if.ulpi_nxt_o;
        tick();
        tr[0] = u_if.ulpi_nxt_o;
        u_if.ulpi_stp_i  = 1'b1;
        u_if.ulpi_data_i = 8'h00;
        tick();
        u_if.ulpi_stp_i = 1'b0;
    endtask

    // Release reset with linestate 01 and check the LineState RX CMD sequence
    task automatic release_and_check_ls(input string tag);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        n_cmp++;
        if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o} !== {2'b10, 8'h00}) begin
            n_fail++;
            $display("FAIL %s_ls_ta1: got dir/nxt/data %b%b/%h required 10/00", tag,
                     u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o);
        end
        tick();
        n_cmp++;
        if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o} !== {2'b10, 8'h0D}) begin
            n_fail++;
            $display("FAIL %s_ls_cmd: got dir/nxt/data %b%b/%h required 10/0d", tag,
                     u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o);
        end
        tick();
        n_cmp++;
        if (u_if.ulpi_dir_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ls_ta2: got dir %b required 0", tag, u_if.ulpi_dir_o);
        end
        tick();
    endtask

    task automatic test_reset;
        rst_i            = 1'b0;
        linestate_i      = 2'b01;
        rx_valid_i       = 1'b0;
        rx_data_i        = 8'h00;
        rx_last_i        = 1'b0;
        u_if.ulpi_data_i = 8'h00;
        u_if.ulpi_stp_i  = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o, rx_ready_o, tx_valid_o,
             tx_data_o, tx_last_o} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dir=%b nxt=%b data=%h rdy=%b txv=%b txd=%h txl=%b required all 0",
                     u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o, rx_ready_o,
                     tx_valid_o, tx_data_o, tx_last_o);
        end
        release_and_check_ls("reset");
    endtask

    task automatic test_reg_read_write;
        logic [7:0] d;
        logic [3:0] rt;
        logic [2:0] wt;
        reg_read(6'h04, d, rt);
        n_cmp++;
        if (d !== 8'h41) begin
            n_fail++;
            $display("FAIL rd_fc_reset: got %h required 41", d);
        end
        n_cmp++;
        if (rt !== 4'b1110) begin
            n_fail++;
            $display("FAIL rd_timing: got %b required 1110", rt);
        end
        reg_write(6'h06, 8'h01, wt);
        n_cmp++;
        if (wt !== 3'b110) begin
            n_fail++;
            $display("FAIL wr_timing: got %b required 110", wt);
        end
        reg_read(6'h04, d, rt);
        n_cmp++;
        if (d !== 8'h40) begin
            n_fail++;
            $display("FAIL rd_fc_after_clear: got %h required 40", d);
        end
    endtask

    task automatic test_regmap;
        logic [7:0] d;
        logic [3:0] rt;
        logic [2:0] wt;
        logic [5:0] addr [5];
        logic [7:0] exp  [5];
        addr = '{6'h04, 6'h00, 6'h01, 6'h02, 6'h3F};
        exp  = '{8'h00, 8'h24, 8'h04, 8'h09, 8'h00};
        reg_write(6'h04, 8'h20, wt);
        for (int i = 0; i < 5; i++) begin
            reg_read(addr[i], d, rt);
            n_cmp++;
            if (d !== exp[i]) begin
                n_fail++;
                $display("FAIL regmap_rd_%h: got %h required %h", addr[i], d, exp[i]);
            end
        end
        // OTG set alias, read back through the clear alias
        reg_write(6'h0B, 8'h80, wt);
        reg_read(6'h0C, d, rt);
        n_cmp++;
        if (d !== 8'h86) begin
            n_fail++;
            $display("FAIL otg_set: got %h required 86", d);
        end
    endtask

    task automatic test_transmit;
        logic [4:0] nt;
        tx_q.delete();
        tx_last_q.delete();
        u_if.ulpi_data_i = 8'h43;
        tick();
        nt[4] = u_if.ulpi_nxt_o;
        u_if.ulpi_data_i = 8'hAA;
        tick();
        nt[3] = u_if.ulpi_nxt_o;
        tick();
        nt[2] = u_if.ulpi_nxt_o;
        u_if.ulpi_data_i = 8'hBB;
        tick();
        nt[1] = u_if.ulpi_nxt_o;
        u_if.ulpi_data_i = 8'h77;
        u_if.ulpi_stp_i  = 1'b1;
        tick();
        nt[0] = u_if.ulpi_nxt_o;
        u_if.ulpi_data_i = 8'h00;
        u_if.ulpi_stp_i  = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (nt !== 5'b11110) begin
            n_fail++;
            $display("FAIL tx_nxt_trace: got %b required 11110", nt);
        end
        n_cmp++;
        if (tx_q.size() != 3) begin
            n_fail++;
            $display("FAIL tx_count: got %0d required 3", tx_q.size());
        end else begin
            n_cmp++;
            if ({tx_q[0], tx_q[1], tx_q[2]} !== 24'hC3AABB) begin
                n_fail++;
                $display("FAIL tx_bytes: got %h %h %h required c3 aa bb",
                         tx_q[0], tx_q[1], tx_q[2]);
            end
            n_cmp++;
            if ({tx_last_q[0], tx_last_q[1], tx_last_q[2]} !== 3'b001) begin
                n_fail++;
                $display("FAIL tx_last: got %b%b%b required 001",
                         tx_last_q[0], tx_last_q[1], tx_last_q[2]);
            end
        end
    endtask

    task automatic test_rx_inject;
        // stimulus {valid,last,data} applied at cycle M+k, ready expected then,
        // bus {dir,nxt,data} expected at cycle M+k+1
        logic [9:0] stim [7];
        logic       rdy  [7];
        logic [9:0] bus  [7];
        stim = '{10'h22D, 10'h22D, 10'h200, 10'h000, 10'h310, 10'h2EE, 10'h000};
        rdy  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bus  = '{10'h300, 10'h32D, 10'h300, 10'h21D, 10'h310, 10'h20D, 10'h000};
        for (int k = 0; k < 7; k++) begin
            {rx_valid_i, rx_last_i, rx_data_i} = stim[k];
            #1;
            n_cmp++;
            if (rx_ready_o !== rdy[k]) begin
                n_fail++;
                $display("FAIL rx_ready_%0d: got %b required %b", k, rx_ready_o, rdy[k]);
            end
            tick();
            n_cmp++;
            if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o} !== bus[k]) begin
                n_fail++;
                $display("FAIL rx_bus_%0d: got dir/nxt/data %b%b/%h required %b%b/%h", k,
                         u_if.ulpi_dir_o, u_if.ulpi_nxt_o, u_if.ulpi_data_o,
                         bus[k][9], bus[k][8], bus[k][7:0]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back_priority;
        logic [7:0] d;
        logic [3:0] rt;
        {rx_valid_i, rx_last_i, rx_data_i} = 10'h3A5;
        u_if.ulpi_data_i = 8'h87;
        tick();
        u_if.ulpi_data_i = 8'h55;
        n_cmp++;
        if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL prio_rx_wins: got dir/nxt %b%b required 11",
                     u_if.ulpi_dir_o, u_if.ulpi_nxt_o);
        end
        tick();
        {rx_valid_i, rx_last_i, rx_data_i} = 10'h000;
        u_if.ulpi_data_i = 8'h00;
        n_cmp++;
        if (u_if.ulpi_data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL prio_rx_byte: got %h required a5", u_if.ulpi_data_o);
        end
        repeat (3) tick();
        reg_read(6'h07, d, rt);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_reg_unchanged: got %h required 00", d);
        end
    endtask

    task automatic test_reset_mid_rx;
        logic [7:0] d;
        logic [3:0] rt;
        {rx_valid_i, rx_last_i, rx_data_i} = 10'h211;
        tick();
        tick();
        #2;
        n_cmp++;
        if (rx_ready_o !== 1'b1 || u_if.ulpi_data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL mid_rx_active: got rdy=%b data=%h required 1/11",
                     rx_ready_o, u_if.ulpi_data_o);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({u_if.ulpi_dir_o, u_if.ulpi_nxt_o, rx_ready_o, u_if.ulpi_data_o} !== 11'h0) begin
            n_fail++;
            $display("FAIL async_reset: got dir=%b nxt=%b rdy=%b data=%h required 0",
                     u_if.ulpi_dir_o, u_if.ulpi_nxt_o, rx_ready_o, u_if.ulpi_data_o);
        end
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        release_and_check_ls("rerst");
        reg_read(6'h04, d, rt);
        n_cmp++;
        if (d !== 8'h41) begin
            n_fail++;
            $display("FAIL rerst_fc: got %h required 41", d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reg_read_write();
        test_regmap();
        test_transmit();
        test_rx_inject();
        test_back_to_back_priority();
        test_reset_mid_rx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
